// File: rtl/swc_pkg.sv
// Shared constants and types for the switch-core read engine.
// Covers descriptor bit positions, FSM state encoding and an index-width helper.
package swc_pkg;

  localparam int DESC_W     = 16;
  localparam int DESC_LAST  = 15;
  localparam int DESC_FIRST = 14;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_GRANT   = 3'd1,
    ST_READ    = 3'd2,
    ST_DRAIN   = 3'd3,
    ST_RELEASE = 3'd4
  } rd_state_e;

  // Port index width; a single-port engine still carries a 1-bit index.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter_n.sv
// Combinational rotating-priority arbiter.
// Grants the first set request bit found scanning upward from rr_ptr, wrapping modulo NPORT.
module rr_arbiter_n
  import swc_pkg::*;
#(
  parameter int NPORT = 4,
  parameter int IDX_W = idx_w(NPORT)
) (
  input  logic [NPORT-1:0] req,
  input  logic [IDX_W-1:0] rr_ptr,
  output logic [NPORT-1:0] gnt,
  output logic [IDX_W-1:0] gnt_idx
);

  always_comb begin : arb
    int   k;
    logic found;
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    k       = 0;
    for (int i = 0; i < NPORT; i++) begin
      k = (int'(rr_ptr) + i) % NPORT;
      if (!found && req[k]) begin
        found   = 1'b1;
        gnt[k]  = 1'b1;
        gnt_idx = IDX_W'(k);
      end
    end
  end

endmodule

// File: rtl/swc_rd_engine.sv
// Output-side read engine: round-robin pick of a queued cell, beat streaming from
// the data SRAM to the output FIFO, and multicast refcount release to the free queue.
//
// state   | meaning
// IDLE    | sample qc_rdy & ~o_bp, latch request vector when non-zero
// GRANT   | arbitrate, ack the grantee, latch descriptor and output select
// READ    | issue one SRAM read per beat, 2^BEAT_W cycles
// DRAIN   | wait RAM_LAT cycles for the last beat to leave the RAM
// RELEASE | decrement refcount, free the pointer on its last copy
module swc_rd_engine
  import swc_pkg::*;
#(
  parameter int NPORT   = 4,
  parameter int PTR_W   = 10,
  parameter int BEAT_W  = 2,
  parameter int DATA_W  = 128,
  parameter int MC_W    = 4,
  parameter int RAM_LAT = 1
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic [NPORT-1:0]        qc_rdy,
  input  logic [NPORT*DESC_W-1:0] qc_ptr,
  output logic [NPORT-1:0]        qc_ack,
  input  logic [NPORT-1:0]        o_bp,
  output logic                    sram_rd_en,
  output logic [PTR_W+BEAT_W-1:0] sram_rd_addr,
  input  logic [DATA_W-1:0]       sram_rd_data,
  output logic [PTR_W-1:0]        mc_rd_addr,
  input  logic [MC_W-1:0]         mc_rd_data,
  output logic                    mc_wr_en,
  output logic [PTR_W-1:0]        mc_wr_addr,
  output logic [MC_W-1:0]         mc_wr_data,
  output logic                    fq_wr,
  output logic [PTR_W-1:0]        fq_din,
  output logic [NPORT-1:0]        o_wr,
  output logic [DATA_W-1:0]       o_din,
  output logic                    o_first,
  output logic                    o_last,
  output logic                    busy,
  output logic                    err_refcnt,
  output logic [31:0]             stat_cells
);

  localparam int IDX_W = idx_w(NPORT);

  rd_state_e          state_q, state_d;
  logic [NPORT-1:0]   req_q, req_d;
  logic [IDX_W-1:0]   rr_q, rr_d;
  logic [NPORT-1:0]   sel_q, sel_d;
  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic               first_q, first_d;
  logic               last_q, last_d;
  logic [BEAT_W-1:0]  beat_q, beat_d;
  logic [1:0]         drain_q, drain_d;
  logic [31:0]        stat_q, stat_d;
  logic               err_q, err_d;
  logic [RAM_LAT-1:0] vld_q, vld_d;
  logic [RAM_LAT-1:0] ofirst_q, ofirst_d;
  logic [RAM_LAT-1:0] olast_q, olast_d;

  logic [NPORT-1:0]   gnt;
  logic [IDX_W-1:0]   gnt_idx;
  logic [DESC_W-1:0]  desc_g;
  logic [NPORT-1:0]   req_now;
  logic               rd_first, rd_last;
  logic               unused_desc;

  rr_arbiter_n #(
    .NPORT (NPORT),
    .IDX_W (IDX_W)
  ) u_arb (
    .req     (req_q),
    .rr_ptr  (rr_q),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  always_comb begin
    desc_g = '0;
    for (int p = 0; p < NPORT; p++) begin
      if (gnt[p]) desc_g = desc_g | qc_ptr[p*DESC_W +: DESC_W];
    end
  end

  // Descriptor bits between the pointer and the framing flags carry nothing here.
  assign unused_desc = ^desc_g;

  assign req_now = qc_rdy & ~o_bp;

  always_comb begin
    state_d      = state_q;
    req_d        = req_q;
    rr_d         = rr_q;
    sel_d        = sel_q;
    ptr_d        = ptr_q;
    first_d      = first_q;
    last_d       = last_q;
    beat_d       = beat_q;
    drain_d      = drain_q;
    stat_d       = stat_q;
    err_d        = err_q;
    qc_ack       = '0;
    sram_rd_en   = 1'b0;
    sram_rd_addr = '0;
    mc_wr_en     = 1'b0;
    mc_wr_addr   = '0;
    mc_wr_data   = '0;
    fq_wr        = 1'b0;
    fq_din       = '0;
    rd_first     = 1'b0;
    rd_last      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (|req_now) begin
          req_d   = req_now;
          state_d = ST_GRANT;
        end
      end
      ST_GRANT: begin
        qc_ack  = gnt;
        sel_d   = gnt;
        ptr_d   = desc_g[PTR_W-1:0];
        first_d = desc_g[DESC_FIRST];
        last_d  = desc_g[DESC_LAST];
        rr_d    = (gnt_idx == IDX_W'(NPORT-1)) ? '0 : gnt_idx + 1'b1;
        beat_d  = '0;
        state_d = ST_READ;
      end
      ST_READ: begin
        sram_rd_en   = 1'b1;
        sram_rd_addr = {ptr_q, beat_q};
        rd_first     = first_q && (beat_q == '0);
        rd_last      = last_q && (&beat_q);
        beat_d       = beat_q + 1'b1;
        if (&beat_q) begin
          drain_d = 2'(RAM_LAT-1);
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (drain_q == '0) state_d = ST_RELEASE;
        else               drain_d = drain_q - 1'b1;
      end
      ST_RELEASE: begin
        mc_wr_en   = 1'b1;
        mc_wr_addr = ptr_q;
        // A zero count is a corrupted cell: free it anyway rather than leak the pointer.
        if (mc_rd_data > MC_W'(1)) begin
          mc_wr_data = mc_rd_data - 1'b1;
        end else begin
          fq_wr  = 1'b1;
          fq_din = ptr_q;
        end
        if (mc_rd_data == '0) err_d = 1'b1;
        stat_d  = stat_q + 32'd1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    vld_d       = '0;
    ofirst_d    = '0;
    olast_d     = '0;
    vld_d[0]    = sram_rd_en;
    ofirst_d[0] = rd_first;
    olast_d[0]  = rd_last;
    for (int i = 1; i < RAM_LAT; i++) begin
      vld_d[i]    = vld_q[i-1];
      ofirst_d[i] = ofirst_q[i-1];
      olast_d[i]  = olast_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= ST_IDLE;
      req_q    <= '0;
      rr_q     <= '0;
      sel_q    <= '0;
      ptr_q    <= '0;
      first_q  <= 1'b0;
      last_q   <= 1'b0;
      beat_q   <= '0;
      drain_q  <= '0;
      stat_q   <= '0;
      err_q    <= 1'b0;
      vld_q    <= '0;
      ofirst_q <= '0;
      olast_q  <= '0;
    end else begin
      state_q  <= state_d;
      req_q    <= req_d;
      rr_q     <= rr_d;
      sel_q    <= sel_d;
      ptr_q    <= ptr_d;
      first_q  <= first_d;
      last_q   <= last_d;
      beat_q   <= beat_d;
      drain_q  <= drain_d;
      stat_q   <= stat_d;
      err_q    <= err_d;
      vld_q    <= vld_d;
      ofirst_q <= ofirst_d;
      olast_q  <= olast_d;
    end
  end

  assign mc_rd_addr = ptr_q;
  assign o_wr       = vld_q[RAM_LAT-1] ? sel_q : '0;
  assign o_din      = vld_q[RAM_LAT-1] ? sram_rd_data : '0;
  assign o_first    = ofirst_q[RAM_LAT-1];
  assign o_last     = olast_q[RAM_LAT-1];
  assign busy       = (state_q != ST_IDLE);
  assign err_refcnt = err_q;
  assign stat_cells = stat_q;

endmodule

// File: doc/swc_rd_engine.md
Name: swc_rd_engine

Overview:
- Parametrised output-side read engine for the shared-buffer switch core.
- Arbitrates cell pointers from NPORT per-port queue controllers using rotating (round-robin) priority, with per-port backpressure masking.
- Streams each granted cell's beats out of the data SRAM to the addressed output FIFO.
- Maintains the multicast reference count for each cell and returns the pointer to the free queue when the last copy has been read.
- Replaces the fixed 4-port / 4-beat read logic. New behaviour: per-beat first/last framing, reference-count underflow detection, and a statistics counter.

Parameters:
- NPORT, 4, number of output ports / queue controllers (2..16)
- PTR_W, 10, cell pointer width
- BEAT_W, 2, log2 of beats per cell (cell = 2^BEAT_W beats)
- DATA_W, 128, data beat width
- MC_W, 4, multicast reference-count width
- RAM_LAT, 1, data/MC RAM read latency in cycles (1 or 2)

Ports:
- clk  in  1  clock
- rstn  in  1  async active-low reset
- qc_rdy  in  NPORT  per-port queue has a pointer ready
- qc_ptr  in  NPORT*16  per-port descriptor: [15] last cell, [14] first cell, [PTR_W-1:0] pointer
- qc_ack  out  NPORT  one-hot pop pulse to the queue controller
- o_bp  in  NPORT  output FIFO backpressure
- sram_rd_en  out  1  data RAM read strobe
- sram_rd_addr  out  PTR_W+BEAT_W  {ptr, beat}
- sram_rd_data  in  DATA_W  data RAM output
- mc_rd_addr  out  PTR_W  refcount RAM read address
- mc_rd_data  in  MC_W  refcount RAM output
- mc_wr_en  out  1  refcount write
- mc_wr_addr  out  PTR_W  refcount write address
- mc_wr_data  out  MC_W  new refcount
- fq_wr  out  1  free-queue push
- fq_din  out  PTR_W  pointer returned to the free queue
- o_wr  out  NPORT  one-hot output FIFO write
- o_din  out  DATA_W  beat data
- o_first  out  1  first beat of a frame
- o_last  out  1  last beat of a frame
- busy  out  1  FSM not in IDLE
- err_refcnt  out  1  sticky: refcount read as 0
- stat_cells  out  32  cells forwarded, wraps at 2^32

Behaviour:
- Reset: every output is 0; rr_ptr=0; FSM=IDLE. The reset is asynchronous, so reset mid-cell aborts the cell with no further ack/fq/o_wr pulses.

FSM states:
- IDLE: req = qc_rdy & ~o_bp. If req != 0, latch req and go to GRANT.
- GRANT (1 cycle):
  - Choose the first set bit of the latched req, scanning from rr_ptr upward modulo NPORT.
  - Latch the grantee's descriptor and a one-hot sel.
  - Pulse qc_ack[grant] for exactly 1 cycle.
  - rr_ptr <= (grant+1) mod NPORT.
  - Go to READ with beat=0.
- READ (2^BEAT_W cycles):
  - sram_rd_en=1; sram_rd_addr={ptr,beat}; beat increments each cycle.
  - mc_rd_addr=ptr is held throughout.
  - After the final beat, wait RAM_LAT cycles (DRAIN), then go to RELEASE.
- RELEASE (1 cycle), acting on the refcount n = mc_rd_data:
  - n==1: mc_wr_data=0 and fq_wr=1 with fq_din=ptr.
  - n>1: mc_wr_data=n-1; no fq_wr.
  - n==0: treat as 1 (write 0, fq_wr=1) and set err_refcnt (sticky until reset).
  - In all cases: mc_wr_en=1, mc_wr_addr=ptr, stat_cells+1; go to IDLE.

Output path:
- o_wr = sel exactly RAM_LAT cycles after each sram_rd_en beat; o_din=sram_rd_data.
- o_first=1 only on beat 0 of a cell whose descriptor has bit14 set.
- o_last=1 only on beat 2^BEAT_W-1 of a cell whose descriptor has bit15 set.
- o_bp is sampled only in IDLE. Output FIFOs must reserve one cell of headroom above their bp threshold.

Timing and hazards:
- Cell period = 2^BEAT_W + RAM_LAT + 3 cycles (IDLE+GRANT+READ+DRAIN+RELEASE).
- Refcount read-modify-write for a multicast pointer queued on several ports is serialised by the FSM. The next read of the same address occurs at least 2 cycles after the RELEASE write, so no bypass is needed.
- If a port's qc_rdy or o_bp changes between IDLE and GRANT, the latched req is used and the grantee's descriptor is still valid, because queue controllers hold qc_rdy until acked.
- NPORT=1 degenerates to a single-source engine: rr_ptr stays 0.

Decomposition:
- swc_pkg:
  - descriptor bit positions (DESC_LAST=15, DESC_FIRST=14)
  - FSM state encoding (IDLE, GRANT, READ, DRAIN, RELEASE)
  - descriptor width constant 16
- Sub-module rr_arbiter_n:
  - Parametrised NPORT, combinational rotating-priority grant from req and rr_ptr.
  - Outputs one-hot grant plus index.
  - Unit-tested separately.

Test Plan:
- NPORT=4, BEAT_W=2, RAM_LAT=1; qc_rdy=0001, ptr=0x005, desc[15:14]=11, refcnt=1 -> sram_rd_addr 0x014..0x017. o_wr=0001 for 4 cycles; o_first on beat 0, o_last on beat 3. fq_wr with fq_din=0x005; mc_wr_data=0; stat_cells=1.
- qc_rdy=1111 held, all refcnt=1 -> grant order 0,1,2,3,0. Each qc_ack is a single-cycle pulse, and consecutive acks are 8 cycles apart.
- Multicast: ptr 0x033 with refcnt=3 on ports 0, 2, 3 -> mc_wr_data sequence 2,1,0. A single fq_wr occurs only after the third cell.
- qc_rdy=0110 with o_bp=0010 -> only port 2 is granted. Releasing o_bp lets port 1 be granted next.
- Refcount RAM preloaded to 0 -> fq_wr asserted and err_refcnt becomes 1 and stays 1.
- rstn asserted during beat 2 of READ -> all outputs 0 in the same cycle, with no fq_wr or mc_wr_en. After release, rr_ptr=0 and grant restarts from port 0.
